eq_band_gain_mixer: RTL

Per-band gain scheduler placed after the 10-output FIR bank. It captures the bank's 10 band samples on each sample strobe. A single shared signed multiplier is time-multiplexed across the bands to apply each band's user gain. The weighted bands are summed, rounded, saturated and presented as one 24-bit equalised sample. Gains are written through a simple register port and applied only at sample boundaries, so a gain change never tears within one sample.

---
 rtl/eq_pkg.sv | 53 +++++
 rtl/eq_gain_regfile.sv | 48 ++++
 rtl/eq_band_gain_mixer.sv | 111 +++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared constants, state encoding and rounding helper for the per-band gain mixer.
package eq_pkg;

  localparam int unsigned NUM_BANDS = 10;
  localparam int unsigned DATA_W    = 24;
  localparam int unsigned GAIN_W    = 16;
  localparam int unsigned GAIN_FRAC = 14;
  localparam int unsigned PROD_W    = DATA_W + GAIN_W;
  localparam int unsigned ACC_W     = DATA_W + GAIN_W + 4;
  localparam int unsigned IDX_W     = 4;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h4000;

  localparam logic [IDX_W-1:0] BAND_LP   = 4'd0;
  localparam logic [IDX_W-1:0] BAND_64   = 4'd1;
  localparam logic [IDX_W-1:0] BAND_250  = 4'd2;
  localparam logic [IDX_W-1:0] BAND_500  = 4'd3;
  localparam logic [IDX_W-1:0] BAND_1K   = 4'd4;
  localparam logic [IDX_W-1:0] BAND_2K   = 4'd5;
  localparam logic [IDX_W-1:0] BAND_4K   = 4'd6;
  localparam logic [IDX_W-1:0] BAND_8K   = 4'd7;
  localparam logic [IDX_W-1:0] BAND_16K  = 4'd8;
  localparam logic [IDX_W-1:0] BAND_HP   = 4'd9;
  localparam logic [IDX_W-1:0] LAST_IDX  = BAND_HP;

  // Half an LSB of the Q1.14 result, for round-half-up.
  localparam logic signed [ACC_W-1:0] ROUND_BIAS =
      {{(ACC_W - GAIN_FRAC){1'b0}}, 1'b1, {(GAIN_FRAC - 1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StSat  = 2'd2
  } eq_state_e;

  function automatic logic [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    logic [DATA_W-1:0]       res;
    r = (acc + ROUND_BIAS) >>> GAIN_FRAC;
    if (r > SAT_MAX) begin
      res = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (r < SAT_MIN) begin
      res = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      res = r[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/eq_gain_regfile.sv
// Pending/active gain registers: writes land in pending, commit copies to active
// with same-cycle write forwarding so a gain written on the accept edge is used.
module eq_gain_regfile
  import eq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [GAIN_W-1:0] wr_data,
  input  logic              commit,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [GAIN_W-1:0] rd_gain
);

  logic [GAIN_W-1:0]    pending_q [NUM_BANDS];
  logic [GAIN_W-1:0]    active_q  [NUM_BANDS];
  logic [NUM_BANDS-1:0] wr_hit;

  // Exact address match also rejects out-of-range addresses.
  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      wr_hit[k] = wr_en && (wr_addr == IDX_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        pending_q[k] <= GAIN_UNITY;
        active_q[k]  <= GAIN_UNITY;
      end
    end else begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        if (wr_hit[k]) begin
          pending_q[k] <= wr_data;
        end
        if (commit) begin
          active_q[k] <= wr_hit[k] ? wr_data : pending_q[k];
        end
      end
    end
  end

  assign rd_gain = active_q[rd_idx];

endmodule

// File: rtl/eq_band_gain_mixer.sv
// Captures the FIR bank's band samples, applies per-band gains with one shared
// multiplier over NUM_BANDS cycles, then rounds and saturates to one output sample.
module eq_band_gain_mixer
  import eq_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          sample_valid,
  input  logic [NUM_BANDS*DATA_W-1:0]   band_in,
  input  logic                          gain_wr_en,
  input  logic [3:0]                    gain_wr_addr,
  input  logic [GAIN_W-1:0]             gain_wr_data,
  output logic [DATA_W-1:0]             audio_out,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun
);

  eq_state_e               state_q;
  logic [DATA_W-1:0]       band_q [NUM_BANDS];
  logic signed [ACC_W-1:0] acc_q;
  logic [IDX_W-1:0]        idx_q;

  logic                    accept;
  logic [GAIN_W-1:0]       gain_sel;
  logic [DATA_W-1:0]       band_sel;
  logic signed [PROD_W-1:0] product;

  assign accept = (state_q == StIdle) && enable && sample_valid;

  eq_gain_regfile u_gain_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (gain_wr_en),
    .wr_addr (gain_wr_addr),
    .wr_data (gain_wr_data),
    .commit  (accept),
    .rd_idx  (idx_q),
    .rd_gain (gain_sel)
  );

  always_comb begin
    band_sel = band_q[idx_q];
    product  = PROD_W'($signed(band_sel)) * PROD_W'($signed(gain_sel));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      idx_q     <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) begin
        band_q[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            for (int k = 0; k < NUM_BANDS; k++) begin
              band_q[k] <= band_in[k*DATA_W +: DATA_W];
            end
            acc_q   <= '0;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StMac;
          end
        end
        StMac: begin
          if (!enable) begin
            acc_q   <= '0;
            idx_q   <= '0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q   <= acc_q + ACC_W'(product);
            idx_q   <= idx_q + 4'd1;
            overrun <= sample_valid;
            if (idx_q == LAST_IDX) begin
              state_q <= StSat;
            end
          end
        end
        StSat: begin
          if (!enable) begin
            acc_q   <= '0;
            idx_q   <= '0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            audio_out <= round_sat(acc_q);
            out_valid <= 1'b1;
            busy      <= 1'b0;
            overrun   <= sample_valid;
            acc_q     <= '0;
            idx_q     <= '0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
